// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants for the 5-stage RISC-V pipeline.
//   NOP_INST     : canonical bubble instruction (addi x0,x0,0)
//   XLEN_DEF     : default PC/address width
//   RESET_PC_DEF : default PC value after reset
package pipe_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int          XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage : pipe_pkg

// File: rtl/if_perf_cnt.sv
// if_perf_cnt
// Three free-running, wrapping performance counters for the fetch stage.
// Ports:
//   clk, rst_n   : pipeline clock, asynchronous active-low reset
//   load_real    : IF/ID captured a real instruction this cycle
//   load_bubble  : IF/ID captured a bubble this cycle
//   stall        : IF/ID was held (en_IFID low) this cycle
//   fetch_cnt    : count of real instruction loads
//   stall_cnt    : count of stalled cycles
//   flush_cnt    : count of bubble loads
module if_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_real,
  input  logic             load_bubble,
  input  logic             stall,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Counters wrap naturally at 2^CNT_W; no saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (load_real)   fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (stall)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (load_bubble) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule : if_perf_cnt

// File: rtl/if_stage.sv
// if_stage
// Instruction-fetch stage: owns the PC register and the IF/ID pipeline
// register. Instruction memory is read combinationally at PC_out and the
// result (inst_in) is captured into IF/ID on the next rising edge.
// Optional feature macro: IF_PERF_CNT_EN enables the performance counters;
// when undefined the counter ports are tied to zero and no counter flops exist.
// Ports:
//   clk, rst_n          : pipeline clock, asynchronous active-low reset
//   en_IF               : PC update enable (0 = hold PC)
//   en_IFID             : IF/ID load enable (0 = hold IF/ID)
//   NOP_IFID            : load a bubble into IF/ID and freeze the PC
//   Control_stall_IF    : control instruction in EX/MEM, apply redirect
//   Branch_taken_EXMem  : that control instruction resolved taken
//   PC_branch_EXMem     : redirect target
//   inst_in             : instruction read from IMem at PC_out
//   PC_out              : current fetch address
//   PC_out_IFID         : PC of the instruction held in IF/ID
//   inst_out_IFID       : instruction held in IF/ID
//   valid_IFID          : IF/ID holds a real instruction
//   fetch_cnt, stall_cnt, flush_cnt : performance counters
module if_stage
  import pipe_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_IF,
  input  logic             en_IFID,
  input  logic             NOP_IFID,
  input  logic             Control_stall_IF,
  input  logic             Branch_taken_EXMem,
  input  logic [XLEN-1:0]  PC_branch_EXMem,
  input  logic [31:0]      inst_in,
  output logic [XLEN-1:0]  PC_out,
  output logic [XLEN-1:0]  PC_out_IFID,
  output logic [31:0]      inst_out_IFID,
  output logic             valid_IFID,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] redirect_pc;

  // Targets are forced word-aligned; the low two bits are simply dropped.
  assign redirect_pc = {PC_branch_EXMem[XLEN-1:2], 2'b00};

  // The redirect has top priority. While a control instruction is in flight
  // the PC was frozen at the fall-through address, so a not-taken outcome
  // just keeps holding it.
  always_comb begin
    pc_next = PC_out;
    if (Control_stall_IF) begin
      if (Branch_taken_EXMem) pc_next = redirect_pc;
    end else if (en_IF && !NOP_IFID) begin
      pc_next = PC_out + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) PC_out <= RESET_PC;
    else        PC_out <= pc_next;
  end

  // A held IF/ID wins over a bubble request: a stalled branch sitting in ID
  // must not be overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC_out_IFID   <= '0;
      inst_out_IFID <= NOP_INST;
      valid_IFID    <= 1'b0;
    end else if (en_IFID) begin
      PC_out_IFID <= PC_out;
      if (NOP_IFID) begin
        inst_out_IFID <= NOP_INST;
        valid_IFID    <= 1'b0;
      end else begin
        inst_out_IFID <= inst_in;
        valid_IFID    <= 1'b1;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic load_real;
  logic load_bubble;
  logic ifid_stall;

  assign load_real   = en_IFID && !NOP_IFID;
  assign load_bubble = en_IFID &&  NOP_IFID;
  assign ifid_stall  = !en_IFID;

  if_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_real   (load_real),
    .load_bubble (load_bubble),
    .stall       (ifid_stall),
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule : if_stage

// File: tb/tb_if_stage.sv
// tb_if_stage
// Self-checking bench for if_stage. A behavioural model of the fetch stage
// is advanced every rising edge and compared against the DUT on every
// falling edge; directed sequences add literal expectations at key points.
module tb_if_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             en_IF;
  logic             en_IFID;
  logic             NOP_IFID;
  logic             Control_stall_IF;
  logic             Branch_taken_EXMem;
  logic [XLEN-1:0]  PC_branch_EXMem;
  logic [31:0]      inst_in;
  logic [XLEN-1:0]  PC_out;
  logic [XLEN-1:0]  PC_out_IFID;
  logic [31:0]      inst_out_IFID;
  logic             valid_IFID;
  logic [CNT_W-1:0] fetch_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en_IF              (en_IF),
    .en_IFID            (en_IFID),
    .NOP_IFID           (NOP_IFID),
    .Control_stall_IF   (Control_stall_IF),
    .Branch_taken_EXMem (Branch_taken_EXMem),
    .PC_branch_EXMem    (PC_branch_EXMem),
    .inst_in            (inst_in),
    .PC_out             (PC_out),
    .PC_out_IFID        (PC_out_IFID),
    .inst_out_IFID      (inst_out_IFID),
    .valid_IFID         (valid_IFID),
    .fetch_cnt          (fetch_cnt),
    .stall_cnt          (stall_cnt),
    .flush_cnt          (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] inst_of(input logic [XLEN-1:0] addr);
    return 32'hC0DE_0000 ^ {addr[15:0], addr[15:0]};
  endfunction

  assign inst_in = inst_of(PC_out);

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model of the fetch stage.
  logic [XLEN-1:0]  m_pc, m_pc_ifid;
  logic [31:0]      m_inst;
  logic             m_valid;
  logic [CNT_W-1:0] m_fetch, m_stall, m_flush;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_pc_ifid = 32'h0; m_inst = 32'h13; m_valid = 1'b0;
      m_fetch = '0; m_stall = '0; m_flush = '0;
    end else begin
      if (!en_IFID) begin
        m_stall = m_stall + 1;
      end else if (NOP_IFID) begin
        m_pc_ifid = m_pc; m_inst = 32'h13; m_valid = 1'b0;
        m_flush = m_flush + 1;
      end else begin
        m_pc_ifid = m_pc; m_inst = inst_of(m_pc); m_valid = 1'b1;
        m_fetch = m_fetch + 1;
      end
      if (Control_stall_IF) begin
        if (Branch_taken_EXMem) m_pc = PC_branch_EXMem & ~32'h3;
      end else if (en_IF && !NOP_IFID) begin
        m_pc = m_pc + 4;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("pc_out", 64'(PC_out), 64'(m_pc));
      checkOutput("pc_ifid", 64'(PC_out_IFID), 64'(m_pc_ifid));
      checkOutput("inst_ifid", 64'(inst_out_IFID), 64'(m_inst));
      checkOutput("valid_ifid", 64'(valid_IFID), 64'(m_valid));
`ifdef IF_PERF_CNT_EN
      checkOutput("fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      checkOutput("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`else
      checkOutput("fetch_cnt", 64'(fetch_cnt), 64'd0);
      checkOutput("stall_cnt", 64'(stall_cnt), 64'd0);
      checkOutput("flush_cnt", 64'(flush_cnt), 64'd0);
`endif
    end
  end

  // Drive one set of controls for n cycles; returns just after a falling edge.
  task automatic applyStimulus(input logic e_if, input logic e_ifid,
                               input logic nop, input logic cs,
                               input logic tk, input logic [XLEN-1:0] tgt,
                               input int n);
    en_IF = e_if; en_IFID = e_ifid; NOP_IFID = nop;
    Control_stall_IF = cs; Branch_taken_EXMem = tk; PC_branch_EXMem = tgt;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en_IF = 1'b1; en_IFID = 1'b1; NOP_IFID = 1'b0;
    Control_stall_IF = 1'b0; Branch_taken_EXMem = 1'b0; PC_branch_EXMem = '0;

    // Reset
    repeat (2) @(negedge clk);
    checkOutput("rst_pc", 64'(PC_out), 64'h0);
    checkOutput("rst_inst", 64'(inst_out_IFID), 64'h13);
    checkOutput("rst_valid", 64'(valid_IFID), 64'h0);
    checkOutput("rst_pc_ifid", 64'(PC_out_IFID), 64'h0);
    rst_n = 1'b1;

    // Sequential fetch
    applyStimulus(1, 1, 0, 0, 0, '0, 1);
    checkOutput("seq_pc", 64'(PC_out), 64'h4);
    checkOutput("seq_inst", 64'(inst_out_IFID), 64'(inst_of(32'h0)));
    checkOutput("seq_valid", 64'(valid_IFID), 64'h1);
    applyStimulus(1, 1, 0, 0, 0, '0, 3);
    checkOutput("seq_pc10", 64'(PC_out), 64'h10);
    checkOutput("seq_pc_ifid", 64'(PC_out_IFID), 64'hC);

    // Data stall
    applyStimulus(0, 0, 0, 0, 0, '0, 2);
    checkOutput("stall_pc", 64'(PC_out), 64'h10);
    checkOutput("stall_pc_ifid", 64'(PC_out_IFID), 64'hC);
    checkOutput("stall_inst", 64'(inst_out_IFID), 64'(inst_of(32'hC)));
    applyStimulus(1, 1, 0, 0, 0, '0, 1);
    checkOutput("resume_pc", 64'(PC_out), 64'h14);
    checkOutput("resume_pc_ifid", 64'(PC_out_IFID), 64'h10);

    // Taken branch to 0x40
    applyStimulus(1, 1, 1, 0, 0, '0, 2);
    checkOutput("br_hold_pc", 64'(PC_out), 64'h14);
    checkOutput("br_bubble", 64'(valid_IFID), 64'h0);
    applyStimulus(1, 1, 1, 1, 1, 32'h40, 1);
    checkOutput("br_target", 64'(PC_out), 64'h40);
    checkOutput("br_bubble3", 64'(valid_IFID), 64'h0);
    applyStimulus(1, 1, 0, 0, 0, '0, 1);
    checkOutput("br_fetch_pc", 64'(PC_out_IFID), 64'h40);
    checkOutput("br_fetch_valid", 64'(valid_IFID), 64'h1);

    // Not-taken: PC holds the fall-through address
    applyStimulus(1, 1, 1, 0, 0, '0, 2);
    applyStimulus(1, 1, 1, 1, 0, 32'h100, 1);
    checkOutput("nt_pc", 64'(PC_out), 64'h44);
    applyStimulus(1, 1, 0, 0, 0, '0, 1);
    checkOutput("nt_next", 64'(PC_out), 64'h48);

    // Misaligned target is word-aligned
    applyStimulus(1, 1, 1, 0, 0, '0, 2);
    applyStimulus(1, 1, 1, 1, 1, 32'h43, 1);
    checkOutput("misalign_pc", 64'(PC_out), 64'h40);
    applyStimulus(1, 1, 0, 0, 0, '0, 1);

    // IF/ID hold beats bubble request
    applyStimulus(1, 0, 1, 0, 0, '0, 1);
    checkOutput("hold_pc_ifid", 64'(PC_out_IFID), 64'h40);
    checkOutput("hold_valid", 64'(valid_IFID), 64'h1);
    checkOutput("hold_inst", 64'(inst_out_IFID), 64'(inst_of(32'h40)));
    checkOutput("hold_pc", 64'(PC_out), 64'h44);

    // Redirect beats en_IF=0 and NOP_IFID
    applyStimulus(0, 1, 1, 1, 1, 32'h80, 1);
    checkOutput("redir_pc", 64'(PC_out), 64'h80);

    // PC wraps past the top of the address space
    applyStimulus(0, 1, 1, 1, 1, 32'hFFFF_FFFE, 1);
    checkOutput("wrap_top", 64'(PC_out), 64'hFFFF_FFFC);
    applyStimulus(1, 1, 0, 0, 0, '0, 1);
    checkOutput("wrap_pc", 64'(PC_out), 64'h0);
    checkOutput("wrap_pc_ifid", 64'(PC_out_IFID), 64'hFFFF_FFFC);
    applyStimulus(1, 1, 0, 0, 0, '0, 1);

    // Mid-stream reset restarts at RESET_PC
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_pc", 64'(PC_out), 64'h0);
    checkOutput("mrst_valid", 64'(valid_IFID), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 10 loads, 2 stalls, 3 bubbles
    applyStimulus(1, 1, 0, 0, 0, '0, 5);
    applyStimulus(0, 0, 0, 0, 0, '0, 2);
    applyStimulus(1, 1, 1, 0, 0, '0, 3);
    applyStimulus(1, 1, 0, 0, 0, '0, 5);
    checkOutput("cnt_pc", 64'(PC_out), 64'h28);
`ifdef IF_PERF_CNT_EN
    checkOutput("cnt_fetch", 64'(fetch_cnt), 64'd10);
    checkOutput("cnt_stall", 64'(stall_cnt), 64'd2);
    checkOutput("cnt_flush", 64'(flush_cnt), 64'd3);
`else
    checkOutput("cnt_fetch", 64'(fetch_cnt), 64'd0);
    checkOutput("cnt_stall", 64'(stall_cnt), 64'd0);
    checkOutput("cnt_flush", 64'(flush_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule : tb_if_stage
